dvi_video_timing: RTL and testbench
===================================

// Module: dvi_video_timing
// PURPOSE
//  Pixel-clock video timing generator and pixel-stream aligner feeding the TMDS/DVI serializer.
//  - Generates de and hsync/vsync from parameterised CEA-style timing.
//  - Consumes an RGB888 valid/ready stream with start-of-frame marker.
//  - Drives registered de, per-channel data (ch0=B, ch1=G, ch2=R) and control (ch0={vsync,hsync}).
// PARAMETERS
//  H_ACTIVE 1280 | H_FP 110 | H_SYNC 40 | H_BP 220   horizontal timing, pixels
//  V_ACTIVE 720  | V_FP 5   | V_SYNC 5  | V_BP 20    vertical timing, lines
//  HSYNC_POL 1, VSYNC_POL 1   sync level while asserted (1=active-high)
// PORTS
//  clk_pix      in   1   pixel clock, sole clock
//  rst_pix      in   1   synchronous, active-high reset
//  s_valid      in   1   stream pixel valid
//  s_ready      out  1   stream pixel accepted when s_valid&s_ready
//  s_data       in   24  {R[23:16],G[15:8],B[7:0]}
//  s_sof        in   1   marks first pixel (0,0) of a frame
//  de           out  1   data enable to serializer
//  data_ch0/1/2 out  8   B / G / R
//  ctrl_ch0     out  2   {vsync,hsync}; ctrl_ch1, ctrl_ch2 out 2, constant 2'b00
//  frame_start  out  1   1-cycle pulse, aligned with de of pixel (0,0)
//  underflow    out  1   1-cycle pulse on stream underflow or misalignment
// BEHAVIOUR
//  - H_TOTAL=sum H_*, V_TOTAL=sum V_*. h_ctr 0..H_TOTAL-1 wraps, v_ctr increments on h wrap, wraps at V_TOTAL.
//  - active = h_ctr<H_ACTIVE && v_ctr<V_ACTIVE. hsync asserted for h_ctr in [H_ACTIVE+H_FP, +H_SYNC);
//    vsync asserted for v_ctr in [V_ACTIVE+V_FP, +V_SYNC) on full lines. Level = POL asserted, ~POL otherwise.
//  - All outputs registered: counter state at cycle n appears on outputs at n+1 (latency 1).
//  - Reset: counters 0, state UNLOCKED, de=0, data_ch*=0, ctrl_ch0={~VSYNC_POL,~HSYNC_POL}, pulses 0.
//  - Reset asserted mid-frame: same, next cycle; any partially consumed frame is abandoned.
//  - s_ready is combinational from state/counters/s_valid/s_sof only (no loop through s_ready).
//  - FSM UNLOCKED:
//    s_ready = s_valid & ~s_sof; non-SOF pixels discarded at any time.
//    A SOF head is held until (h,v)=(0,0); then consumed, state->LOCKED.
//    Active pixels output black (de=1, data 0).
//  - FSM LOCKED: s_ready = active & ~(s_valid & s_sof & (h,v)!=(0,0)); consumed pixel goes to data_ch*.
//  - LOCKED, active & ~s_valid: pixel black, underflow pulse, ->UNLOCKED.
//  - LOCKED, SOF at active position !=(0,0): not consumed, pixel black, underflow pulse, ->UNLOCKED.
//    Re-locks at the next (0,0).
//  - LOCKED at (0,0) with non-SOF head: treated as misalignment (same as above).
//  - Blanking: de=0, data_ch*=0, no stream consumption while LOCKED.
// CONFIGURATION
//  DVI_TESTPATTERN_EN defined: adds input pattern_en (1 bit).
//    pattern_en=1 -> s_ready=0, FSM held UNLOCKED, underflow=0.
//    Active pixels output 8 vertical bars, bar=(h_ctr*8)/H_ACTIVE (constant thresholds, no divider).
//    Bar order: white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
//    pattern_en sampled each cycle; takes effect on the next output pixel.
//  Macro undefined: no pattern_en port, no pattern logic.
// TESTING (params H 8/2/2/2 -> H_TOTAL 14; V 4/1/1/1 -> V_TOTAL 7; frame 98 cycles)
//  1. Release reset, s_valid=0 -> de high 8 cycles/line on lines 0-3; hsync at h=10,11; vsync on line 5;
//     frame_start every 98 cycles; data 0; underflow pulse on first active pixel? no: UNLOCKED => none.
//  2. Continuous stream, SOF on pixel 0, s_data=k -> 32 pixels/frame consumed; data_ch0=k[7:0]
//     one cycle after accept; no underflow.
//  3. Stream starting with 3 non-SOF pixels -> all 3 accepted immediately and dropped; lock at next (0,0);
//     first de pixel = SOF data.
//  4. LOCKED, s_valid=0 at (3,1) -> that pixel 0x000000, underflow 1 cycle, s_ready=0 for rest of frame
//     except non-SOF drops; relocks next frame.
//  5. rst_pix for 1 cycle at (5,2) mid-stream -> next cycle de=0, ctrl inactive, counters restart at (0,0),
//     UNLOCKED.
//  6. DVI_TESTPATTERN_EN, pattern_en=1 -> line pixel h=0..7 = FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,FF0000,
//     0000FF,000000; s_ready=0.

Source files
------------

// File: rtl/dvi_video_timing.sv
// dvi_video_timing: CEA-style video timing generator and RGB888 stream aligner for a DVI serializer.
// Build option DVI_TESTPATTERN_EN adds pattern_en, which replaces the stream with 8 colour bars.
module dvi_video_timing #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
`ifdef DVI_TESTPATTERN_EN
    input  logic        pattern_en,
`endif
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    output logic        de,
    output logic [7:0]  data_ch0,
    output logic [7:0]  data_ch1,
    output logic [7:0]  data_ch2,
    output logic [1:0]  ctrl_ch0,
    output logic [1:0]  ctrl_ch1,
    output logic [1:0]  ctrl_ch2,
    output logic        frame_start,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    logic [HW-1:0] h_ctr;
    logic [VW-1:0] v_ctr;
    state_t        state, state_n;
    logic          active, origin, h_wrap, v_wrap;
    logic          hs_on, vs_on, take, uf_n, pat;
    logic [23:0]   pix;

    assign h_wrap = int'(h_ctr) == H_TOTAL - 1;
    assign v_wrap = int'(v_ctr) == V_TOTAL - 1;
    assign active = int'(h_ctr) < H_ACTIVE && int'(v_ctr) < V_ACTIVE;
    assign origin = h_ctr == '0 && v_ctr == '0;
    assign hs_on  = int'(h_ctr) >= H_ACTIVE + H_FP &&
                    int'(h_ctr) <  H_ACTIVE + H_FP + H_SYNC;
    assign vs_on  = int'(v_ctr) >= V_ACTIVE + V_FP &&
                    int'(v_ctr) <  V_ACTIVE + V_FP + V_SYNC;

`ifdef DVI_TESTPATTERN_EN
    logic [2:0] bar;
    assign pat = pattern_en;

    // bar = (h*8)/H_ACTIVE via constant thresholds ceil(k*H_ACTIVE/8)
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(h_ctr) >= (k * H_ACTIVE + 7) / 8) bar = bar + 3'd1;
        end
    end
`else
    assign pat = 1'b0;
`endif

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            h_ctr <= '0;
            v_ctr <= '0;
        end else if (h_wrap) begin
            h_ctr <= '0;
            v_ctr <= v_wrap ? '0 : v_ctr + 1'b1;
        end else begin
            h_ctr <= h_ctr + 1'b1;
        end
    end

    // Unlocked: drop non-SOF heads, hold SOF until the frame origin
    always_comb begin
        s_ready = 1'b0;
        if (!pat) begin
            if (state == UNLOCKED) s_ready = s_valid & (~s_sof | origin);
            else s_ready = active & ~(s_valid & (s_sof ^ origin));
        end
    end

    assign take = s_valid & s_ready;

    always_comb begin
        state_n = state;
        uf_n    = 1'b0;
        if (pat) begin
            state_n = UNLOCKED;
        end else begin
            unique case (state)
                UNLOCKED: if (take & s_sof) state_n = LOCKED;
                LOCKED: begin
                    if (active & ~take) begin
                        state_n = UNLOCKED;
                        uf_n    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pix = 24'h0;
        if (take && (state == LOCKED || s_sof)) pix = s_data;
`ifdef DVI_TESTPATTERN_EN
        if (pat && active) pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
`endif
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state       <= UNLOCKED;
            de          <= 1'b0;
            data_ch0    <= 8'h0;
            data_ch1    <= 8'h0;
            data_ch2    <= 8'h0;
            ctrl_ch0    <= {~VSYNC_POL, ~HSYNC_POL};
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_n;
            de          <= active;
            data_ch0    <= pix[7:0];
            data_ch1    <= pix[15:8];
            data_ch2    <= pix[23:16];
            ctrl_ch0    <= {vs_on ? VSYNC_POL : ~VSYNC_POL,
                            hs_on ? HSYNC_POL : ~HSYNC_POL};
            frame_start <= origin;
            underflow   <= uf_n;
        end
    end

    assign ctrl_ch1 = 2'b00;
    assign ctrl_ch2 = 2'b00;

endmodule

// File: tb/tb_dvi_video_timing.sv
// tb_dvi_video_timing: randomized stream bench with a frame-position reference model.
// Small timing (14x7, 98-cycle frame); pattern checks only when DVI_TESTPATTERN_EN is defined.
`timescale 1ns/1ps
module tb_dvi_video_timing;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int FT = HT * (VA + VF + VS + VB);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic [23:0] s_data = 24'h0;
    logic        pat_en = 1'b0;
    logic        s_ready, de, fs, uf;
    logic [7:0]  c0, c1, c2;
    logic [1:0]  k0, k1, k2;

    int checks = 0;
    int failures = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    dvi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .clk_pix(clk), .rst_pix(rst),
`ifdef DVI_TESTPATTERN_EN
        .pattern_en(pat_en),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
        .de(de), .data_ch0(c0), .data_ch1(c1), .data_ch2(c2),
        .ctrl_ch0(k0), .ctrl_ch1(k1), .ctrl_ch2(k2),
        .frame_start(fs), .underflow(uf)
    );

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s @%0t got=%h want=%h", n, $time, a, e);
        end
    endtask

    // Reference: position is cycles since reset modulo the frame
    int  mt = 0;
    bit  mlock = 0, mok = 0;
    logic        e_de, e_fs, e_uf;
    logic [1:0]  e_ctrl;
    logic [23:0] e_pix;

    function automatic bit m_act(int t);
        return (t % HT) < HA && (t / HT) < VA;
    endfunction

    function automatic bit m_ready(int t, bit lk, bit v, bit sof, bit p);
        bit org = (t == 0);
        if (p) return 1'b0;
        if (!lk) return v && (!sof || org);
        return m_act(t) && !(v && (sof != org));
    endfunction

    always @(posedge clk) begin
        bit tk;
        if (rst) begin
            mt = 0; mlock = 0; mok = 1;
            e_de = 0; e_pix = 0; e_ctrl = 2'b00; e_fs = 0; e_uf = 0;
        end else if (mok) begin
            tk     = s_valid && m_ready(mt, mlock, s_valid, s_sof, pat_en);
            e_de   = m_act(mt);
            e_ctrl = {mt / HT == VA + VF,
                      (mt % HT) >= HA + HF && (mt % HT) < HA + HF + HS};
            e_fs   = (mt == 0);
            e_uf   = mlock && e_de && !tk && !pat_en;
            e_pix  = (tk && (mlock || s_sof)) ? s_data : 24'h0;
            if (pat_en && e_de) e_pix = bars[(mt % HT) * 8 / HA];
            if (pat_en) mlock = 0;
            else if (tk && s_sof) mlock = 1;
            else if (mlock && e_de && !tk) mlock = 0;
            mt = (mt + 1) % FT;
        end
    end

    always @(negedge clk) begin
        if (mok) begin
            chk("de", 32'(de), 32'(e_de));
            chk("pixel", 32'({c2, c1, c0}), 32'(e_pix));
            chk("ctrl_ch0", 32'(k0), 32'(e_ctrl));
            chk("ctrl_ch12", 32'({k1, k2}), 32'h0);
            chk("frame_start", 32'(fs), 32'(e_fs));
            chk("underflow", 32'(uf), 32'(e_uf));
            if (!rst)
                chk("s_ready", 32'(s_ready),
                    32'(m_ready(mt, mlock, s_valid, s_sof, pat_en)));
        end
    end

    // Stream source and per-window statistics
    int p = 0;
    logic [23:0] cur = 24'h0, sof_data = 24'h0;
    bit want = 0, fsof = 0, hs = 0, sof_hs = 0;
    int drop_at = -1, rst_at = -1;
    int n_de, n_fs, n_uf, n_hs, n_hsync, n_vsync;

    task automatic clear_stats();
        n_de = 0; n_fs = 0; n_uf = 0; n_hs = 0; n_hsync = 0; n_vsync = 0;
    endtask

    task automatic cycle();
        bit drop;
        @(posedge clk); #1;
        if (hs) begin p = (p + 1) % 32; cur = $urandom; end
        if (rst_at >= 0 && mt == rst_at) begin rst = 1; rst_at = -1; end
        else rst = 0;
        drop = (drop_at >= 0 && mt == drop_at);
        if (drop) drop_at = -1;
        s_valid = want && !rst && !drop;
        s_sof   = (p == 0) || fsof;
        s_data  = cur;
        @(negedge clk);
        if (sof_hs) chk("sof_pixel_data", 32'({c2, c1, c0}), 32'(sof_data));
        hs = s_valid && s_ready;
        sof_hs = hs && s_sof && !pat_en;
        if (sof_hs) sof_data = s_data;
        if (de) n_de++;
        if (fs) n_fs++;
        if (uf) n_uf++;
        if (hs) n_hs++;
        if (k0[0]) n_hsync++;
        if (k0[1]) n_vsync++;
    endtask

    task automatic run_frame();
        clear_stats();
        repeat (FT) cycle();
    endtask

    task automatic wait_t(int target);
        int n = 0;
        do begin cycle(); n++; end while (mt != target && n < 3 * FT);
        chk("wait_position", 32'(mt), 32'(target));
    endtask

    initial begin
        int n;
        cur = $urandom;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_de", 32'(de), 32'h0);
        chk("reset_ctrl", 32'(k0), 32'h0);
        chk("reset_fs", 32'(fs), 32'h0);
        chk("reset_uf", 32'(uf), 32'h0);

        // idle timing, unlocked
        run_frame();
        run_frame();
        chk("idle_de_count", 32'(n_de), 32'd32);
        chk("idle_fs_count", 32'(n_fs), 32'd1);
        chk("idle_uf_count", 32'(n_uf), 32'd0);
        chk("idle_hsync_count", 32'(n_hsync), 32'd14);
        chk("idle_vsync_count", 32'(n_vsync), 32'd14);
        n = 0;
        do begin cycle(); n++; end while (!fs && n < 2 * FT);
        n = 0;
        do begin cycle(); n++; end while (!fs && n < 2 * FT);
        chk("frame_period", 32'(n), 32'(FT));

        // continuous stream locks at origin
        want = 1; p = 0;
        wait_t(FT - 1);
        run_frame();
        chk("lock_hs_count", 32'(n_hs), 32'd32);
        chk("lock_uf_count", 32'(n_uf), 32'd0);
        run_frame();
        chk("stream_hs_count", 32'(n_hs), 32'd32);
        chk("stream_uf_count", 32'(n_uf), 32'd0);

        // stream stops: one underflow, then unlocked
        want = 0;
        run_frame();
        chk("stop_uf_count", 32'(n_uf), 32'd1);

        // three stray pixels dropped, SOF held to origin
        p = 29; want = 1;
        clear_stats();
        wait_t(FT - 1);
        chk("stray_drop_count", 32'(n_hs), 32'd3);
        run_frame();
        chk("relock_hs_count", 32'(n_hs), 32'd32);
        chk("relock_uf_count", 32'(n_uf), 32'd0);

        // gap at (3,1)
        drop_at = HT + 3;
        run_frame();
        chk("gap_uf_count", 32'(n_uf), 32'd1);
        run_frame();
        chk("gap_relock_uf", 32'(n_uf), 32'd0);
        chk("gap_relock_hs", 32'(n_hs), 32'd32);

        // reset at (5,2)
        rst_at = 2 * HT + 5;
        wait_t(2 * HT + 5);
        cycle();
        chk("midrst_de", 32'(de), 32'h0);
        chk("midrst_ctrl", 32'(k0), 32'h0);
        chk("midrst_pos", 32'(mt), 32'd0);
        wait_t(FT - 1);
        run_frame();
        chk("midrst_relock_hs", 32'(n_hs), 32'd32);
        chk("midrst_relock_uf", 32'(n_uf), 32'd0);

`ifdef DVI_TESTPATTERN_EN
        pat_en = 1;
        wait_t(FT - 1);
        run_frame();
        chk("pattern_hs_count", 32'(n_hs), 32'd0);
        chk("pattern_uf_count", 32'(n_uf), 32'd0);
        pat_en = 0;
`endif

        // randomized traffic
        repeat (3000) begin
            want = ($urandom % 8) != 0;
            fsof = ($urandom % 24) == 0;
            if ($urandom % 600 == 0) rst_at = $urandom % FT;
`ifdef DVI_TESTPATTERN_EN
            if ($urandom % 200 == 0) pat_en = ~pat_en;
`endif
            cycle();
        end
        fsof = 0;
        pat_en = 0;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout @%0t got=running want=finished", $time);
        $fatal(1);
    end

endmodule
